// File: rtl/bus_fifo_if.sv
// Valid/ready handshake bundle for bus_fifo: producer side (i_*) and consumer side (o_*).
// The FIFO uses the slave modport; the driving environment uses master.
interface bus_fifo_if #(
    parameter int DW = 8
);
    logic          i_vld;
    logic          i_rdy;
    logic [DW-1:0] i_dat;
    logic          o_vld;
    logic          o_rdy;
    logic [DW-1:0] o_dat;

    modport master (
        output i_vld, i_dat, o_rdy,
        input  i_rdy, o_vld, o_dat
    );

    modport slave (
        input  i_vld, i_dat, o_rdy,
        output i_rdy, o_vld, o_dat
    );
endinterface

// File: rtl/bus_fifo.sv
// Elastic valid/ready FIFO of DEPTH x DW entries with occupancy output.
// Define BUS_FIFO_BYPASS_EN for a zero-latency pass-through when the buffer is empty.
module bus_fifo #(
    parameter  int DW    = 8,
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    bus_fifo_if.slave     bus,
    output logic [CW-1:0] cnt
);
    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          active_q;
    logic [DW-1:0] mem_q [DEPTH];

    logic full, empty, push, pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full  = (cnt_q == CW'(DEPTH));
    assign empty = (cnt_q == '0);

    // active_q keeps i_rdy low through reset and rises on the first edge after release
    assign bus.i_rdy = active_q && !full;
    assign pop       = !empty && bus.o_rdy;
    assign cnt       = cnt_q;

`ifdef BUS_FIFO_BYPASS_EN
    logic byp;
    assign byp       = active_q && empty && bus.i_vld;
    assign bus.o_vld = !empty || byp;
    assign bus.o_dat = byp ? bus.i_dat : mem_q[rd_ptr_q];
    // a word taken straight through never touches storage
    assign push      = bus.i_vld && bus.i_rdy && !(byp && bus.o_rdy);
`else
    assign bus.o_vld = !empty;
    assign bus.o_dat = mem_q[rd_ptr_q];
    assign push      = bus.i_vld && bus.i_rdy;
`endif

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            active_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= bus.i_dat;
    end
endmodule

// File: tb/tb_bus_fifo.sv
// Self-checking bench for bus_fifo: directed scenarios plus random traffic against a queue model.
// Honours BUS_FIFO_BYPASS_EN to select the expected empty-buffer behaviour.
module tb_bus_fifo;
    localparam int DW    = 4;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);
`ifdef BUS_FIFO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [CW-1:0] cnt;

    bus_fifo_if #(.DW(DW)) bif ();

    bus_fifo #(.DW(DW), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif),
        .cnt   (cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] model_q [$];
    bit            m_active = 1'b0;
    bit            hold_prev = 1'b0;
    logic [DW-1:0] dat_prev = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive, check outputs against the model, then advance the model on the edge.
    task automatic cyc(input logic v, input logic [DW-1:0] d, input logic r, output bit acc);
        bit            e_rdy, e_vld, byp, pop;
        logic [DW-1:0] e_dat;
        bif.i_vld = v;
        bif.i_dat = d;
        bif.o_rdy = r;
        #1;
        e_rdy = m_active && (model_q.size() < DEPTH);
        byp   = BYP && e_rdy && (model_q.size() == 0) && v;
        e_vld = (model_q.size() != 0) || byp;
        check("i_rdy", 32'(bif.i_rdy), 32'(e_rdy));
        check("o_vld", 32'(bif.o_vld), 32'(e_vld));
        check("cnt", 32'(cnt), 32'(model_q.size()));
        if (e_vld) begin
            e_dat = byp ? d : model_q[0];
            check("o_dat", 32'(bif.o_dat), 32'(e_dat));
        end
        if (hold_prev) check("prod_hold", 32'({v, d}), 32'({1'b1, dat_prev}));
        hold_prev = v && !bif.i_rdy && rst_n;
        dat_prev  = d;
        @(posedge clk);
        acc = 1'b0;
        if (rst_n) begin
            acc = e_rdy && v;
            pop = r && e_vld;
            if (pop && !byp) void'(model_q.pop_front());
            if (acc && !(byp && r)) model_q.push_back(d);
            m_active = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic release_reset();
        rst_n = 1'b1;
        @(posedge clk);
        m_active = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        bit            a, pend, v, r;
        logic [DW-1:0] d;
        bif.i_vld = 1'b0;
        bif.i_dat = '0;
        bif.o_rdy = 1'b0;
        @(negedge clk);

        // reset held three cycles
        repeat (3) cyc(1'b0, '0, 1'b0, a);
        release_reset();
        cyc(1'b0, '0, 1'b0, a);

        // fill, hold off a fifth word, then drain
        for (int k = 1; k <= 4; k++) cyc(1'b1, DW'(k), 1'b0, a);
        cyc(1'b1, DW'(5), 1'b0, a);
        check("fill_held", 32'(a), 32'(0));
        pend = 1'b1;
        for (int k = 0; k < 8; k++) begin
            cyc(pend, DW'(5), 1'b1, a);
            if (a) pend = 1'b0;
        end
        cyc(1'b0, '0, 1'b0, a);

        // streaming through the pointer wrap
        for (int k = 0; k < 10; k++) cyc(1'b1, DW'(k), 1'b1, a);
        cyc(1'b0, '0, 1'b1, a);
        cyc(1'b0, '0, 1'b0, a);

        // full with a simultaneous pop: the waiting word must not slip in
        for (int k = 1; k <= 4; k++) cyc(1'b1, DW'(k + 8), 1'b0, a);
        cyc(1'b1, DW'(10), 1'b1, a);
        check("full_pop_no_wr", 32'(a), 32'(0));
        cyc(1'b1, DW'(10), 1'b0, a);
        for (int k = 0; k < 5; k++) cyc(1'b0, '0, 1'b1, a);

        // asynchronous reset between edges
        for (int k = 1; k <= 3; k++) cyc(1'b1, DW'(k + 2), 1'b0, a);
        bif.i_vld = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_cnt", 32'(cnt), 32'(0));
        check("arst_o_vld", 32'(bif.o_vld), 32'(0));
        check("arst_i_rdy", 32'(bif.i_rdy), 32'(0));
        model_q.delete();
        m_active  = 1'b0;
        hold_prev = 1'b0;
        @(negedge clk);
        repeat (2) cyc(1'b0, '0, 1'b0, a);
        release_reset();
        cyc(1'b1, DW'(7), 1'b0, a);
        cyc(1'b0, '0, 1'b1, a);
        cyc(1'b0, '0, 1'b0, a);

        // empty buffer with producer and consumer both ready
        cyc(1'b1, DW'(12), 1'b1, a);
        cyc(1'b0, '0, 1'b1, a);
        cyc(1'b0, '0, 1'b0, a);

        // random traffic with varying consumer pressure
        pend = 1'b0;
        v    = 1'b0;
        d    = '0;
        for (int i = 0; i < 400; i++) begin
            if (!pend) begin
                v = ($urandom_range(0, 3) != 0);
                d = DW'($urandom);
            end
            case (i / 100)
                0:       r = ($urandom_range(0, 3) == 0);
                1:       r = ($urandom_range(0, 3) != 0);
                2:       r = 1'b1;
                default: r = ($urandom_range(0, 1) != 0);
            endcase
            cyc(v, d, r, a);
            pend = v && !a;
        end
        for (int k = 0; k < 2 * DEPTH; k++) begin
            cyc(pend, d, 1'b1, a);
            if (a) pend = 1'b0;
        end
        cyc(1'b0, '0, 1'b0, a);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bus_fifo.md
Name: bus_fifo

Overview:
- Parametrised successor to the single-register bus buffer.
- Elastic buffer of DEPTH entries, each DW bits wide, with a valid/ready handshake on both sides.
- Sits between a bus producer and a bus consumer, absorbing backpressure and rate mismatch.
- Reports occupancy for flow-control monitoring.

Parameters:
DW, 8, data width in bits (>=1)
DEPTH, 4, number of storage entries (>=2, any integer, not limited to powers of two)
CW, $clog2(DEPTH+1), occupancy counter width (derived localparam, not overridable)

Ports:
clk  input  1  clock; all state updates on posedge
rst_n  input  1  asynchronous reset, active-low
i_vld  input  1  producer data valid
i_rdy  output  1  buffer can accept (not full)
i_dat  input  DW  producer data
o_vld  output  1  buffer has data for consumer
o_rdy  input  1  consumer accepts
o_dat  output  DW  data at head of buffer
cnt  output  CW  current number of stored entries, 0..DEPTH

Behaviour:
- Reset:
  - Asserting rst_n=0 at any time, including mid-transfer, immediately clears wr_ptr, rd_ptr and cnt to 0.
  - While in reset, o_vld=0 and i_rdy=0.
  - i_rdy rises in the first cycle after rst_n deasserts. Storage array is not reset.
- Push: occurs on a clock edge with i_vld && i_rdy.
  - mem[wr_ptr] <= i_dat.
  - wr_ptr advances by 1; after DEPTH-1 it wraps to 0.
- Pop: occurs on a clock edge with o_vld && o_rdy; rd_ptr advances with the same wrap rule.
- cnt update per edge:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on both or neither.
  - Never exceeds DEPTH, never underflows.
- Status outputs are derived from registered cnt:
  - i_rdy = (cnt != DEPTH).
  - o_vld = (cnt != 0).
- o_dat = mem[rd_ptr]. It is don't-care while o_vld=0; the bench must not check it then.
- Latency: data pushed at edge N appears on o_dat with o_vld=1 after edge N (available from cycle N+1). One-cycle minimum latency.
- Full (cnt==DEPTH):
  - i_rdy=0, so i_vld is ignored even if a pop occurs in the same cycle. No write-through when full.
  - After a pop, i_rdy=1 in the next cycle.
- Empty (cnt==0): o_vld=0 and o_rdy is ignored.
- Simultaneous push and pop at 0<cnt<DEPTH: both pointers advance and cnt holds.
- Ordering: strict FIFO. No data loss or duplication.
- Producer rule (bench asserts this): i_dat must stay stable while i_vld=1 && i_rdy=0, and i_vld must not drop before acceptance.
- DW usage: DW sets the widths of i_dat, o_dat and mem; no other logic depends on DW.

Optional Feature:
Macro BUS_FIFO_BYPASS_EN.
- Defined:
  - When cnt==0 and i_vld=1: o_vld=1 and o_dat=i_dat combinationally.
  - If o_rdy=1 in that same cycle, the word passes through with zero latency. It is not written, and pointers and cnt are unchanged.
  - If o_rdy=0, the word is pushed normally.
  - i_rdy is unchanged (still !full).
- Not defined: behaviour exactly as in Behaviour above, with no combinational path from i_* to o_*.

Test Plan:
1. Reset: DW=4, DEPTH=4, rst_n low 3 cycles then high -> o_vld=0, cnt=0; i_rdy=0 during reset and 1 on the first cycle after release.
2. Fill/drain: push 0x1,0x2,0x3,0x4 with o_rdy=0 -> cnt=4, i_rdy=0. A fifth push of 0x5 is held off. Then o_rdy=1 -> outputs 0x1..0x4 in order, cnt returns to 0, o_vld=0.
3. Streaming with wrap: i_vld=o_rdy=1 continuously for 10 words 0x0..0x9 starting empty -> outputs 0x0..0x9, each one cycle after push; cnt stays 1 in steady state; pointers wrap twice.
4. Full plus simultaneous pop: cnt=4, i_vld=1 with 0xA, o_rdy=1 for one cycle -> head popped, 0xA not accepted, cnt=3. Next cycle i_rdy=1 and 0xA is accepted, cnt=4.
5. Async reset mid-operation: cnt=3, drop rst_n between edges -> cnt=0 and o_vld=0 immediately without waiting for a clock edge. After release, the first pushed word 0x7 is the first output.
6. BUS_FIFO_BYPASS_EN defined: empty, i_vld=o_rdy=1, i_dat=0xC -> o_dat=0xC and o_vld=1 in the same cycle, cnt stays 0. Without the macro -> 0xC appears one cycle later and cnt pulses to 1.
